// File: rtl/qupls_regfile_lvt_pkg.sv
// Shared types and constants for the LVT-based physical register file.
package qupls_regfile_lvt_pkg;

    localparam int PREGS    = 128;
    localparam int WIDTH    = 64;
    localparam int NWRPORTS = 4;

    typedef logic [$clog2(PREGS)-1:0] pregno_t;
    typedef logic [WIDTH-1:0]         value_t;

    // LVT entry width: enough bits to name any write port, never less than one.
    function automatic int unsigned lvt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int LVTW = lvt_width(NWRPORTS);
    typedef logic [LVTW-1:0] lvt_ent_t;

endpackage

// File: rtl/qupls_regfile_bank.sv
// One register bank: single write port, NRD synchronous read ports with
// read-old-data behaviour, built from NRD replicated simple-dual-port RAMs.
module qupls_regfile_bank #(
    parameter int WID   = 64,
    parameter int PREGS = 128,
    parameter int NRD   = 15
) (
    input  logic                                 clk,
    input  logic                                 i_we,
    input  logic [$clog2(PREGS)-1:0]             i_wa,
    input  logic [WID-1:0]                       i_wd,
    input  logic [NRD-1:0][$clog2(PREGS)-1:0]    i_ra,
    output logic [NRD-1:0][WID-1:0]              o_rd
);

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [WID-1:0] r_mem [PREGS];
        logic [WID-1:0] r_q;

        // Shared write, private read; the read returns the pre-write contents.
        always_ff @(posedge clk) begin
            if (i_we) r_mem[i_wa] <= i_wd;
            r_q <= r_mem[i_ra[g]];
        end

        assign o_rd[g] = r_q;
    end

endmodule

// File: rtl/qupls_regfile_lvt.sv
// Multi-write, multi-read physical register file. A live value table records
// which write port last wrote each register and steers reads to that bank.
// Same-cycle writes are forwarded to reads (write-first); a ready scoreboard
// tracks allocate/writeback state.
module qupls_regfile_lvt
    import qupls_regfile_lvt_pkg::*;
#(
    parameter int NWR    = NWRPORTS,
    parameter int NRD    = 15,
    parameter int NALLOC = 4,
    parameter int PREGS  = qupls_regfile_lvt_pkg::PREGS,
    parameter int WID    = $bits(value_t)
) (
    input  logic                                  rst,
    input  logic                                  clk,
    input  logic [NWR-1:0]                        wr,
    input  logic [NWR-1:0][$clog2(PREGS)-1:0]     wa,
    input  logic [NWR-1:0][WID-1:0]               wd,
    input  logic [NALLOC-1:0]                     alloc,
    input  logic [NALLOC-1:0][$clog2(PREGS)-1:0]  aa,
    input  logic [NRD-1:0][$clog2(PREGS)-1:0]     ra,
    output logic [NRD-1:0][WID-1:0]               o,
    output logic [NRD-1:0]                        ov,
    output logic                                  wr_conflict
);

    localparam int LW = lvt_width(NWR);

    logic [NWR-1:0]                     w_we;
    logic [NWR-1:0][NRD-1:0][WID-1:0]   w_bank_q;
    logic [NRD-1:0]                     w_hit;
    logic [NRD-1:0]                     w_ahit;
    logic [NRD-1:0][WID-1:0]            w_byp;
    logic                               w_conflict;
    logic [PREGS-1:0]                   w_rdy_d;

    logic [LW-1:0]                      r_lvt [PREGS];
    logic [PREGS-1:0]                   r_rdy;
    logic [NRD-1:0][LW-1:0]             r_sel;
    logic [NRD-1:0]                     r_zero;
    logic [NRD-1:0]                     r_hit;
    logic [NRD-1:0][WID-1:0]            r_byp;
    logic [NRD-1:0]                     r_ov;
    logic                               r_conflict;

    assign w_we = wr & {NWR{~rst}};

    for (genvar k = 0; k < NWR; k++) begin : g_bank
        qupls_regfile_bank #(
            .WID   (WID),
            .PREGS (PREGS),
            .NRD   (NRD)
        ) u_bank (
            .clk  (clk),
            .i_we (w_we[k]),
            .i_wa (wa[k]),
            .i_wd (wd[k]),
            .i_ra (ra),
            .o_rd (w_bank_q[k])
        );
    end

    // Write/alloc hits per read port; later ports override earlier ones.
    always_comb begin
        w_hit  = '0;
        w_ahit = '0;
        w_byp  = '0;
        for (int g = 0; g < NRD; g++) begin
            for (int k = 0; k < NWR; k++) begin
                if (wr[k] && wa[k] == ra[g]) begin
                    w_hit[g] = 1'b1;
                    w_byp[g] = wd[k];
                end
            end
            for (int a = 0; a < NALLOC; a++) begin
                if (alloc[a] && aa[a] == ra[g]) w_ahit[g] = 1'b1;
            end
        end
    end

    // Two or more ports writing the same nonzero register.
    always_comb begin
        w_conflict = 1'b0;
        for (int k = 0; k < NWR; k++) begin
            for (int j = k + 1; j < NWR; j++) begin
                if (wr[k] && wr[j] && wa[k] == wa[j] && wa[k] != '0) w_conflict = 1'b1;
            end
        end
    end

    // Ready next-state: writes set, allocs clear (alloc applied last so it wins).
    always_comb begin
        w_rdy_d = r_rdy;
        for (int k = 0; k < NWR; k++) begin
            if (wr[k] && wa[k] != '0) w_rdy_d[wa[k]] = 1'b1;
        end
        for (int a = 0; a < NALLOC; a++) begin
            if (alloc[a] && aa[a] != '0) w_rdy_d[aa[a]] = 1'b0;
        end
        w_rdy_d[0] = 1'b1;
    end

    // LVT update; the highest-numbered port wins on a shared address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PREGS; i++) r_lvt[i] <= '0;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (wr[k] && wa[k] != '0) r_lvt[wa[k]] <= LW'(k);
            end
        end
    end

    // Ready scoreboard state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rdy <= '1;
        else     r_rdy <= w_rdy_d;
    end

    // Read-side pipeline: bank select, bypass data and ready, aligned with bank reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel      <= '0;
            r_zero     <= '1;
            r_hit      <= '0;
            r_byp      <= '0;
            r_ov       <= '0;
            r_conflict <= 1'b0;
        end else begin
            for (int g = 0; g < NRD; g++) begin
                r_sel[g]  <= r_lvt[ra[g]];
                r_zero[g] <= (ra[g] == '0);
                r_ov[g]   <= (ra[g] == '0) | w_hit[g] | (r_rdy[ra[g]] & ~w_ahit[g]);
            end
            r_hit      <= w_hit;
            r_byp      <= w_byp;
            r_conflict <= w_conflict;
        end
    end

    // Final read mux: zero register, forwarded write, or the LVT-selected bank.
    always_comb begin
        o = '0;
        for (int g = 0; g < NRD; g++) begin
            if (r_zero[g])     o[g] = '0;
            else if (r_hit[g]) o[g] = r_byp[g];
            else               o[g] = w_bank_q[r_sel[g]][g];
        end
    end

    assign ov          = r_ov;
    assign wr_conflict = r_conflict;

endmodule

// File: tb/tb_qupls_regfile_lvt.sv
// Randomised bench for qupls_regfile_lvt against a flat behavioural model,
// plus directed literal checks and a small NWR=2 build for LVT redirection.
module tb_qupls_regfile_lvt;

    localparam int NWR = 4, NRD = 15, NAL = 4, NP = 128, WID = 64, AW = 7;
    localparam int NWR2 = 2, NRD2 = 3, NP2 = 64, AW2 = 6;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [NWR-1:0]              wr;
    logic [NWR-1:0][AW-1:0]      wa;
    logic [NWR-1:0][WID-1:0]     wd;
    logic [NAL-1:0]              alloc;
    logic [NAL-1:0][AW-1:0]      aa;
    logic [NRD-1:0][AW-1:0]      ra;
    logic [NRD-1:0][WID-1:0]     o;
    logic [NRD-1:0]              ov;
    logic                        wr_conflict;

    logic [NWR2-1:0]             wr2;
    logic [NWR2-1:0][AW2-1:0]    wa2;
    logic [NWR2-1:0][WID-1:0]    wd2;
    logic [0:0]                  alloc2;
    logic [0:0][AW2-1:0]         aa2;
    logic [NRD2-1:0][AW2-1:0]    ra2;
    logic [NRD2-1:0][WID-1:0]    o2;
    logic [NRD2-1:0]             ov2;
    logic                        wr_conflict2;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference model: one flat memory plus ready and known-valid flags.
    logic [WID-1:0] m_mem   [NP];
    bit             m_known [NP];
    bit             m_rdy   [NP];
    logic [WID-1:0] exp_o     [NRD];
    bit             exp_ov    [NRD];
    bit             exp_known [NRD];
    bit             exp_conf = 1'b0;

    always #5 clk = ~clk;

    qupls_regfile_lvt #(
        .NWR(NWR), .NRD(NRD), .NALLOC(NAL), .PREGS(NP), .WID(WID)
    ) dut (
        .rst(rst), .clk(clk), .wr(wr), .wa(wa), .wd(wd), .alloc(alloc), .aa(aa),
        .ra(ra), .o(o), .ov(ov), .wr_conflict(wr_conflict)
    );

    qupls_regfile_lvt #(
        .NWR(NWR2), .NRD(NRD2), .NALLOC(1), .PREGS(NP2), .WID(WID)
    ) dut2 (
        .rst(rst), .clk(clk), .wr(wr2), .wa(wa2), .wd(wd2), .alloc(alloc2), .aa(aa2),
        .ra(ra2), .o(o2), .ov(ov2), .wr_conflict(wr_conflict2)
    );

    task automatic chk(input string nm, input logic [WID-1:0] act, input logic [WID-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: outputs from pre-edge state, then apply writes and allocs.
    always @(posedge clk) begin : model
        logic [AW-1:0]  a;
        bit             hit, ahit;
        logic [WID-1:0] d;
        int             pairs;
        if (rst) begin
            for (int i = 0; i < NP; i++) begin
                m_rdy[i]   = 1'b1;
                m_known[i] = 1'b0;
            end
            for (int g = 0; g < NRD; g++) begin
                exp_o[g] = '0; exp_ov[g] = 1'b0; exp_known[g] = 1'b1;
            end
            exp_conf = 1'b0;
        end else begin
            for (int g = 0; g < NRD; g++) begin
                a = ra[g]; hit = 1'b0; ahit = 1'b0; d = '0;
                for (int k = 0; k < NWR; k++)
                    if (wr[k] && wa[k] == a) begin hit = 1'b1; d = wd[k]; end
                for (int j = 0; j < NAL; j++)
                    if (alloc[j] && aa[j] == a) ahit = 1'b1;
                if (a == 0) begin
                    exp_o[g] = '0; exp_ov[g] = 1'b1; exp_known[g] = 1'b1;
                end else if (hit) begin
                    exp_o[g] = d; exp_ov[g] = 1'b1; exp_known[g] = 1'b1;
                end else begin
                    exp_o[g] = m_mem[a]; exp_known[g] = m_known[a];
                    exp_ov[g] = m_rdy[a] && !ahit;
                end
            end
            pairs = 0;
            for (int k = 0; k < NWR; k++)
                for (int j = k + 1; j < NWR; j++)
                    if (wr[k] && wr[j] && wa[k] == wa[j] && wa[k] != 0) pairs++;
            exp_conf = (pairs > 0);
            for (int k = 0; k < NWR; k++)
                if (wr[k] && wa[k] != 0) begin
                    m_mem[wa[k]] = wd[k]; m_known[wa[k]] = 1'b1; m_rdy[wa[k]] = 1'b1;
                end
            for (int j = 0; j < NAL; j++)
                if (alloc[j] && aa[j] != 0) m_rdy[aa[j]] = 1'b0;
        end
    end

    // Compare DUT against the model every cycle, away from the clock edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int g = 0; g < NRD; g++) begin
                if (exp_known[g]) chk($sformatf("o[%0d]", g), o[g], exp_o[g]);
                chk($sformatf("ov[%0d]", g), WID'(ov[g]), WID'(exp_ov[g]));
            end
            chk("wr_conflict", WID'(wr_conflict), WID'(exp_conf));
        end
    end

    task automatic idle();
        wr = '0; wa = '0; wd = '0; alloc = '0; aa = '0; ra = '0;
        wr2 = '0; wa2 = '0; wd2 = '0; alloc2 = '0; aa2 = '0; ra2 = '0;
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic randomize_inputs();
        for (int k = 0; k < NWR; k++) begin
            wr[k] = 1'($urandom_range(0, 1));
            wa[k] = AW'($urandom_range(0, 31));
            wd[k] = {$urandom, $urandom};
        end
        for (int j = 0; j < NAL; j++) begin
            alloc[j] = ($urandom_range(0, 3) == 0);
            aa[j]    = AW'($urandom_range(0, 31));
        end
        for (int g = 0; g < NRD; g++)
            ra[g] = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, NP - 1))
                                                : AW'($urandom_range(0, 31));
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(posedge clk);
        chk_en = 1'b1;
        repeat (3) cyc();
        chk("rst o[0]", o[0], '0);
        chk("rst ov[0]", WID'(ov[0]), '0);
        chk("rst wr_conflict", WID'(wr_conflict), '0);

        // First reads after reset: nonzero registers report ready.
        rst = 1'b0; ra[0] = 5; ra[1] = 100;
        cyc();
        chk("post-rst ov[0]", WID'(ov[0]), 1);
        chk("post-rst ov[1]", WID'(ov[1]), 1);
        cyc();
        chk("post-rst ov[0] again", WID'(ov[0]), 1);

        // Write-first bypass, then bank read.
        idle(); wr[2] = 1; wa[2] = 9; wd[2] = 64'hA5; ra[3] = 9;
        cyc();
        chk("bypass o[3]", o[3], 64'hA5);
        chk("bypass ov[3]", WID'(ov[3]), 1);
        idle(); ra[3] = 9;
        cyc();
        chk("bank o[3]", o[3], 64'hA5);

        // Same-register multi-write: conflict pulse, highest port wins.
        idle(); wr[0] = 1; wa[0] = 12; wd[0] = 1; wr[3] = 1; wa[3] = 12; wd[3] = 3;
        cyc();
        chk("conflict pulse", WID'(wr_conflict), 1);
        idle(); ra[5] = 12;
        cyc();
        chk("conflict cleared", WID'(wr_conflict), 0);
        chk("conflict winner o[5]", o[5], 3);

        // Allocate clears ready; write sets it; both at once leaves it clear.
        idle(); alloc[1] = 1; aa[1] = 20;
        cyc();
        idle(); ra[0] = 20;
        cyc();
        chk("alloc ov[0]", WID'(ov[0]), 0);
        idle(); wr[1] = 1; wa[1] = 20; wd[1] = 7;
        cyc();
        idle(); ra[0] = 20;
        cyc();
        chk("write after alloc o[0]", o[0], 7);
        chk("write after alloc ov[0]", WID'(ov[0]), 1);
        idle(); alloc[0] = 1; aa[0] = 20; wr[2] = 1; wa[2] = 20; wd[2] = 8;
        cyc();
        idle(); ra[0] = 20;
        cyc();
        chk("alloc+write ov[0]", WID'(ov[0]), 0);
        chk("alloc+write o[0]", o[0], 8);

        // Register 0 is hardwired and excluded from conflict detection.
        idle(); wr[0] = 1; wa[0] = 0; wd[0] = 64'hFF; wr[1] = 1; wa[1] = 0; wd[1] = 64'hFF;
        ra[2] = 0;
        cyc();
        chk("r0 o[2]", o[2], 0);
        chk("r0 ov[2]", WID'(ov[2]), 1);
        idle(); ra[2] = 0;
        cyc();
        chk("r0 no conflict", WID'(wr_conflict), 0);
        chk("r0 o[2] later", o[2], 0);

        // Two-port build: LVT redirects reg 63 from bank 1 back to bank 0.
        idle(); wr2[1] = 1; wa2[1] = 63; wd2[1] = 64'h111;
        cyc();
        idle(); ra2[0] = 63;
        cyc();
        chk("nwr2 port1 o2[0]", o2[0], 64'h111);
        idle(); wr2[0] = 1; wa2[0] = 63; wd2[0] = 64'h222;
        cyc();
        idle(); ra2[0] = 63; ra2[2] = 63;
        cyc();
        chk("nwr2 redirect o2[0]", o2[0], 64'h222);
        chk("nwr2 redirect o2[2]", o2[2], 64'h222);
        chk("nwr2 redirect ov2[0]", WID'(ov2[0]), 1);

        // Random traffic with one asynchronous reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            idle();
            randomize_inputs();
            rst = (i >= 1500 && i < 1503);
            cyc();
        end
        rst = 1'b0;
        idle();
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
